// File: rtl/funct_generator_seq_ctrl.sv
// Burst sequencer for the funct_generator multiply path: pops operand pairs,
// drives the signed multiplier, registers each product and pushes it downstream.
module funct_generator_seq_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start_i,
    input  logic [CNT_WIDTH-1:0]      num_ops_i,
    input  logic                      fifo_empty_i,
    output logic                      fifo_rd_o,
    input  logic [DATA_WIDTH-1:0]     fifo_data_i,
    output logic                      mult_en_o,
    output logic [DATA_WIDTH-1:0]     mult_a_o,
    output logic [DATA_WIDTH-1:0]     mult_b_o,
    input  logic [2*DATA_WIDTH-1:0]   mult_data_i,
    input  logic                      out_full_i,
    output logic                      out_wr_o,
    output logic [2*DATA_WIDTH-1:0]   out_data_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic [2:0]                dbg_state
);

    localparam int DATA_WIDTH_OUT = 2 * DATA_WIDTH;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_A  = 3'd1,
        CAP_A = 3'd2,
        RD_B  = 3'd3,
        CAP_B = 3'd4,
        MULT  = 3'd5,
        WR    = 3'd6,
        DONE  = 3'd7
    } state_t;

    state_t                    state;
    state_t                    state_nxt;
    logic [CNT_WIDTH-1:0]      num_ops;
    logic [CNT_WIDTH-1:0]      cnt;
    logic [CNT_WIDTH-1:0]      cnt_inc;

    assign cnt_inc   = cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    assign dbg_state = state;

    // Handshakes: a pop happens on a cycle with fifo_rd_o=1 (only issued when
    // !fifo_empty_i), data follows one cycle later; a push happens on a cycle
    // with out_wr_o=1 (only issued when !out_full_i).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            num_ops    <= '0;
            cnt        <= '0;
            mult_a_o   <= '0;
            mult_b_o   <= '0;
            out_data_o <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        num_ops <= num_ops_i;
                        cnt     <= '0;
                    end
                end
                CAP_A: mult_a_o <= fifo_data_i;
                CAP_B: mult_b_o <= fifo_data_i;
                MULT:  out_data_o <= mult_data_i[DATA_WIDTH_OUT-1:0];
                WR: begin
                    if (!out_full_i) cnt <= cnt_inc;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        fifo_rd_o = 1'b0;
        mult_en_o = 1'b0;
        out_wr_o  = 1'b0;
        busy_o    = (state != IDLE);
        done_o    = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) state_nxt = (num_ops_i == '0) ? DONE : RD_A;
            end
            RD_A: begin
                if (!fifo_empty_i) begin
                    fifo_rd_o = 1'b1;
                    state_nxt = CAP_A;
                end
            end
            CAP_A: state_nxt = RD_B;
            RD_B: begin
                if (!fifo_empty_i) begin
                    fifo_rd_o = 1'b1;
                    state_nxt = CAP_B;
                end
            end
            CAP_B: state_nxt = MULT;
            MULT: begin
                mult_en_o = 1'b1;
                state_nxt = WR;
            end
            WR: begin
                if (!out_full_i) begin
                    out_wr_o  = 1'b1;
                    // Compare the incremented count so N = 2^CNT_WIDTH-1 ends exactly.
                    state_nxt = (cnt_inc == num_ops) ? DONE : RD_A;
                end
            end
            DONE: begin
                done_o    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_funct_generator_seq_ctrl.sv
// Directed bench for funct_generator_seq_ctrl with an operand FIFO model,
// a behavioural signed multiplier and a result capture queue.
module tb_funct_generator_seq_ctrl;

    localparam int DW = 32;
    localparam int CW = 8;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CAPB = 3'd4;
    localparam logic [2:0] S_WR   = 3'd6;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start_i = 1'b0;
    logic [CW-1:0]   num_ops_i = '0;
    logic            fifo_empty;
    logic            fifo_rd;
    logic [DW-1:0]   fifo_data = '0;
    logic            mult_en;
    logic [DW-1:0]   mult_a;
    logic [DW-1:0]   mult_b;
    logic [2*DW-1:0] mult_data;
    logic            out_full = 1'b0;
    logic            out_wr;
    logic [2*DW-1:0] out_data;
    logic            busy;
    logic            done;
    logic [2:0]      dbg_state;

    logic [DW-1:0]   op_mem [0:63];
    int              op_n = 0;
    int              rd_ptr = 0;
    logic            hold_empty = 1'b0;
    logic [2*DW-1:0] got_q [$];
    int              proto_err = 0;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    funct_generator_seq_ctrl #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .num_ops_i    (num_ops_i),
        .fifo_empty_i (fifo_empty),
        .fifo_rd_o    (fifo_rd),
        .fifo_data_i  (fifo_data),
        .mult_en_o    (mult_en),
        .mult_a_o     (mult_a),
        .mult_b_o     (mult_b),
        .mult_data_i  (mult_data),
        .out_full_i   (out_full),
        .out_wr_o     (out_wr),
        .out_data_o   (out_data),
        .busy_o       (busy),
        .done_o       (done),
        .dbg_state    (dbg_state)
    );

    assign fifo_empty = hold_empty || (rd_ptr >= op_n);
    assign mult_data  = 64'($signed(mult_a)) * 64'($signed(mult_b));

    always @(posedge clk) begin
        if (fifo_rd) begin
            if (fifo_empty) proto_err = proto_err + 1;
            fifo_data <= op_mem[rd_ptr];
            rd_ptr    <= rd_ptr + 1;
        end
        if (out_wr) begin
            if (out_full) proto_err = proto_err + 1;
            got_q.push_back(out_data);
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [DW-1:0] v);
        op_mem[op_n] = v;
        op_n = op_n + 1;
    endtask

    task automatic start(input logic [CW-1:0] n);
        start_i   = 1'b1;
        num_ops_i = n;
        step();
        start_i   = 1'b0;
        num_ops_i = 8'hAA;
    endtask

    task automatic wait_push(input int n, input string tag);
        for (int i = 0; i < 200 && got_q.size() < n; i++) step();
        check(tag, 64'(got_q.size() >= n), 64'd1);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 200 && busy; i++) step();
        check(tag, 64'(busy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pops;
        int pushes;

        // Reset state
        step(); step();
        check("rst_state", 64'(dbg_state), 64'(S_IDLE));
        check("rst_busy",  64'(busy), 64'd0);
        check("rst_outs",  64'({fifo_rd, mult_en, out_wr, done}), 64'd0);
        check("rst_data",  out_data | 64'(mult_a) | 64'(mult_b), 64'd0);
        rst_n = 1'b1;
        step();

        // 1: 3 * -4, cycle-exact walk through the FSM
        load(32'd3); load(32'hFFFF_FFFC);
        start(8'd1);
        check("t1_rda_rd",   64'(fifo_rd), 64'd1);
        check("t1_rda_busy", 64'(busy), 64'd1);
        step();
        check("t1_capa_rd",  64'(fifo_rd), 64'd0);
        step();
        check("t1_rdb_a",    64'(mult_a), 64'd3);
        check("t1_rdb_rd",   64'(fifo_rd), 64'd1);
        step();
        check("t1_capb_en",  64'(mult_en), 64'd0);
        step();
        check("t1_mult_en",  64'(mult_en), 64'd1);
        check("t1_mult_b",   64'(mult_b), 64'h0000_0000_FFFF_FFFC);
        step();
        check("t1_wr",       64'(out_wr), 64'd1);
        check("t1_wr_data",  out_data, 64'hFFFF_FFFF_FFFF_FFF4);
        step();
        check("t1_done",     64'(done), 64'd1);
        check("t1_pushes",   64'(got_q.size()), 64'd1);
        check("t1_result",   got_q[0], 64'hFFFF_FFFF_FFFF_FFF4);
        step();
        check("t1_done_off", 64'(done), 64'd0);
        check("t1_idle",     64'(busy), 64'd0);

        // 2: extreme operands, N=2
        got_q.delete();
        load(32'h7FFF_FFFF); load(32'h7FFF_FFFF);
        load(32'h8000_0000); load(32'h8000_0000);
        start(8'd2);
        wait_push(2, "t2_timeout");
        check("t2_res0", got_q[0], 64'h3FFF_FFFF_0000_0001);
        check("t2_res1", got_q[1], 64'h4000_0000_0000_0000);
        wait_idle("t2_idle");

        // 3: operand FIFO empty for 5 cycles after start
        got_q.delete();
        hold_empty = 1'b1;
        load(32'd5); load(32'd6);
        start(8'd1);
        for (int i = 0; i < 5; i++) begin
            check("t3_stall_rd",   64'(fifo_rd), 64'd0);
            check("t3_stall_busy", 64'(busy), 64'd1);
            step();
        end
        hold_empty = 1'b0;
        wait_push(1, "t3_timeout");
        check("t3_result", got_q[0], 64'd30);
        wait_idle("t3_idle");

        // 4: result FIFO full for 4 cycles in WR
        got_q.delete();
        out_full = 1'b1;
        load(32'hFFFF_FFFE); load(32'd9);
        start(8'd1);
        for (int i = 0; i < 50 && dbg_state != S_WR; i++) step();
        check("t4_reach_wr", 64'(dbg_state), 64'(S_WR));
        for (int i = 0; i < 4; i++) begin
            check("t4_full_wr",   64'(out_wr), 64'd0);
            check("t4_full_data", out_data, 64'hFFFF_FFFF_FFFF_FFEE);
            step();
        end
        check("t4_no_push", 64'(got_q.size()), 64'd0);
        out_full = 1'b0;
        #1;
        check("t4_wr_after", 64'(out_wr), 64'd1);
        step();
        check("t4_pushes", 64'(got_q.size()), 64'd1);
        check("t4_result", got_q[0], 64'hFFFF_FFFF_FFFF_FFEE);
        wait_idle("t4_idle");

        // 5: N=0 -> straight to DONE
        got_q.delete();
        pops = rd_ptr;
        start(8'd0);
        check("t5_done",     64'(done), 64'd1);
        check("t5_rd",       64'(fifo_rd), 64'd0);
        step();
        check("t5_done_off", 64'(done), 64'd0);
        check("t5_idle",     64'(busy), 64'd0);
        check("t5_pops",     64'(rd_ptr - pops), 64'd0);
        check("t5_pushes",   64'(got_q.size()), 64'd0);

        // 6: reset during CAP_B, then a fresh burst
        load(32'd5); load(32'd7);
        start(8'd1);
        step(); step(); step();
        check("t6_capb", 64'(dbg_state), 64'(S_CAPB));
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("t6_rst_state", 64'(dbg_state), 64'(S_IDLE));
        check("t6_rst_outs",  64'({fifo_rd, mult_en, out_wr, done, busy}), 64'd0);
        check("t6_rst_data",  out_data | 64'(mult_a) | 64'(mult_b), 64'd0);
        step(); step(); step(); step(); step(); step();
        check("t6_no_push",   64'(got_q.size()), 64'd0);
        load(32'd4); load(32'hFFFF_FFFA);
        start(8'd1);
        wait_push(1, "t6_timeout");
        check("t6_result", got_q[0], 64'hFFFF_FFFF_FFFF_FFE8);
        wait_idle("t6_idle");

        // N=3 burst exercises the counter end condition
        got_q.delete();
        load(32'd1); load(32'd2); load(32'd3); load(32'd4);
        load(32'hFFFF_FFFB); load(32'd6);
        pops = rd_ptr;
        start(8'd3);
        wait_push(3, "t7_timeout");
        wait_idle("t7_idle");
        pushes = got_q.size();
        check("t7_pushes", 64'(pushes), 64'd3);
        check("t7_res0", got_q[0], 64'd2);
        check("t7_res1", got_q[1], 64'd12);
        check("t7_res2", got_q[2], 64'hFFFF_FFFF_FFFF_FFE2);
        check("t7_pops", 64'(rd_ptr - pops), 64'd6);

        check("protocol", 64'(proto_err), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
